decoder_bcd: RTL and testbench



---
 rtl/decoder_bcd.sv | 72 +++++++
 tb/tb_decoder_bcd.sv | 123 ++++++++++++
 2 files changed

// File: rtl/decoder_bcd.sv
// Switch value to four active-low seven-segment digits: registered input,
// combinational double-dabble conversion, registered segment outputs.
module decoder_bcd #(
    parameter int unsigned N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] BCD_in_sw,
    output logic [0:6]   D_unidades,
    output logic [0:6]   D_decenas,
    output logic [0:6]   D_centenas,
    output logic [0:6]   D_miles
);

    localparam logic [0:6] SEG_ZERO  = 7'b0000001;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    logic [N-1:0] in_q;
    logic [15:0]  bcd;
    logic [N-1:0] bin;

    function automatic logic [0:6] seg7(input logic [3:0] digit);
        logic [0:6] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Shift-add-3: the binary value is shifted MSB-first into the BCD field,
    // with every nibble of 5 or more corrected by +3 before each shift.
    always_comb begin
        bcd = '0;
        bin = in_q;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (bcd[4*k +: 4] >= 4'd5) begin
                    bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], bin[N-1]};
            bin = bin << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q       <= '0;
            D_unidades <= SEG_ZERO;
            D_decenas  <= SEG_ZERO;
            D_centenas <= SEG_ZERO;
            D_miles    <= SEG_ZERO;
        end else begin
            in_q       <= BCD_in_sw;
            D_unidades <= seg7(bcd[3:0]);
            D_decenas  <= seg7(bcd[7:4]);
            D_centenas <= seg7(bcd[11:8]);
            D_miles    <= seg7(bcd[15:12]);
        end
    end

endmodule

// File: tb/tb_decoder_bcd.sv
// Scoreboard bench for decoder_bcd: expected displays are queued when an input
// is driven and compared two edges later; directed constants cross-check the model.
module tb_decoder_bcd;

    localparam int unsigned N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] BCD_in_sw;
    logic [0:6]   D_unidades, D_decenas, D_centenas, D_miles;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [27:0] ZERO4 = {4{7'b0000001}};

    logic [27:0] sb[$];

    decoder_bcd #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .BCD_in_sw  (BCD_in_sw),
        .D_unidades (D_unidades),
        .D_decenas  (D_decenas),
        .D_centenas (D_centenas),
        .D_miles    (D_miles)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] model(input int unsigned v);
        return {SEG_TAB[(v / 1000) % 10], SEG_TAB[(v / 100) % 10],
                SEG_TAB[(v / 10) % 10], SEG_TAB[v % 10]};
    endfunction

    task automatic check_one(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [27:0] exp);
        check_one({tag, ".miles"},    D_miles,    exp[27:21]);
        check_one({tag, ".centenas"}, D_centenas, exp[20:14]);
        check_one({tag, ".decenas"},  D_decenas,  exp[13:7]);
        check_one({tag, ".unidades"}, D_unidades, exp[6:0]);
    endtask

    // One clock cycle: drive inputs, queue the display they will produce,
    // then compare the display due at this edge.
    task automatic cycle(input int unsigned v, input logic r);
        logic [27:0] due;
        BCD_in_sw = v[N-1:0];
        rst       = r;
        if (r) begin
            if (sb.size() == 0) sb.push_back(ZERO4);
            else sb[sb.size()-1] = ZERO4;
            sb.push_back(ZERO4);
        end else begin
            sb.push_back(model(v));
        end
        @(posedge clk);
        #1;
        due = sb.pop_front();
        check_all("sb", due);
    endtask

    initial begin
        rst = 1'b1;
        BCD_in_sw = '0;

        cycle(1023, 1'b1);
        cycle(1023, 1'b1);
        check_all("reset", ZERO4);
        cycle(1023, 1'b0);
        check_all("reset_release_edge1", ZERO4);
        cycle(1023, 1'b0);
        check_all("v1023", {7'b1001111, 7'b0000001, 7'b0010010, 7'b0000110});

        cycle(0, 1'b0);
        cycle(0, 1'b0);
        check_all("v0", ZERO4);

        cycle(999, 1'b0);
        cycle(999, 1'b0);
        check_all("v999", {7'b0000001, 7'b0000100, 7'b0000100, 7'b0000100});

        cycle(512, 1'b0);
        cycle(512, 1'b0);
        check_all("v512", {7'b0000001, 7'b0100100, 7'b1001111, 7'b0010010});

        cycle(1000, 1'b0);
        cycle(1000, 1'b0);
        check_all("v1000", {7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001});

        cycle(5, 1'b0);
        cycle(6, 1'b0);
        check_all("b2b_5", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100});
        cycle(7, 1'b0);
        check_all("b2b_6", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100000});
        cycle(7, 1'b0);
        check_all("b2b_7", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0001111});

        for (int i = 0; i < 500; i++) cycle($urandom_range(0, 1023), 1'b0);
        cycle(877, 1'b1);
        check_all("mid_reset", ZERO4);
        cycle(877, 1'b0);
        check_all("mid_reset_release", ZERO4);
        for (int i = 0; i < 500; i++) cycle($urandom_range(0, 1023), 1'b0);
        cycle(0, 1'b0);
        cycle(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
